// File: rtl/calc_pkg.sv
// Shared calculator definitions: frame constants, ALU error codes and FSM encodings
// for the result transmitter.
package calc_pkg;

   localparam logic [7:0]  FRAME_SYNC  = 8'hA5;
   localparam int unsigned FRAME_BYTES = 7;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_OVF  = 2'b01;
   localparam logic [1:0] ERR_DIV0 = 2'b10;

   typedef enum logic [1:0] {
      UartIdle,
      UartStart,
      UartData,
      UartStop
   } uart_state_e;

   typedef enum logic {
      FrameIdle,
      FrameSend
   } frame_state_e;

endpackage

// File: rtl/uart_byte_tx.sv
// UART 8N1 byte serialiser. A new byte offered during the last stop-bit cycle is taken
// immediately, so consecutive bytes leave the line with no idle gap.
module uart_byte_tx
   import calc_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_ready,
   output logic       byte_done,
   output logic       tx
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

   uart_state_e     state;
   logic [CntW-1:0] clk_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;
   logic            bit_end;

   assign bit_end    = (clk_cnt == CntMax);
   // Last cycle of the stop bit: the byte is complete and the next one may be loaded.
   assign byte_done  = (state == UartStop) && bit_end;
   assign byte_ready = (state == UartIdle) || byte_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= UartIdle;
         clk_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= 1'b1;
      end else begin
         case (state)
            UartIdle: begin
               clk_cnt <= '0;
               bit_idx <= '0;
               tx      <= 1'b1;
               if (byte_valid) begin
                  shift <= byte_data;
                  tx    <= 1'b0;
                  state <= UartStart;
               end
            end
            UartStart: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  bit_idx <= '0;
                  tx      <= shift[0];
                  state   <= UartData;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            UartData: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= UartStop;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     tx      <= shift[1];
                     shift   <= {1'b0, shift[7:1]};
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            UartStop: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (byte_valid) begin
                     shift <= byte_data;
                     tx    <= 1'b0;
                     state <= UartStart;
                  end else begin
                     tx    <= 1'b1;
                     state <= UartIdle;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= UartIdle;
            end
         endcase
      end
   end

endmodule

// File: rtl/calc_result_tx.sv
// Returns one ALU result per handshake to the host as a framed UART message:
// sync, result bytes MSB-first, status, XOR checksum of result and status bytes.
module calc_result_tx
   import calc_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 10,
   parameter int unsigned DATA_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [DATA_W-1:0] result,
   input  logic [1:0]        error_code,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam int unsigned NumData = DATA_W / 8;
   localparam int unsigned IdxW    = $clog2(NumData + 3);
   localparam logic [IdxW-1:0] StatIdx = IdxW'(NumData + 1);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NumData + 2);

   frame_state_e      state;
   logic [DATA_W-1:0] data_reg;
   logic [1:0]        err_reg;
   logic [IdxW-1:0]   byte_idx;
   logic [IdxW-1:0]   next_idx;
   logic [7:0]        csum;
   logic [7:0]        next_byte;
   logic              accept;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              byte_done;

   // load_ready is high exactly when the frame FSM is idle.
   assign accept = load_valid && load_ready;

   always_comb begin
      csum = {6'b0, err_reg};
      for (int i = 0; i < int'(NumData); i++) begin
         csum = csum ^ data_reg[8*i +: 8];
      end
      next_idx  = byte_idx + 1'b1;
      next_byte = FRAME_SYNC;
      if (next_idx == StatIdx) begin
         next_byte = {6'b0, err_reg};
      end else if (next_idx == LastIdx) begin
         next_byte = csum;
      end else begin
         for (int i = 1; i <= int'(NumData); i++) begin
            if (next_idx == IdxW'(i)) next_byte = data_reg[DATA_W-8*i +: 8];
         end
      end
   end

   // The sync byte goes straight to the serialiser on accept so the start bit follows at once.
   assign byte_valid = accept || ((state == FrameSend) && (byte_idx != LastIdx));
   assign byte_data  = accept ? FRAME_SYNC : next_byte;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FrameIdle;
         data_reg   <= '0;
         err_reg    <= '0;
         byte_idx   <= '0;
         busy       <= 1'b0;
         load_ready <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            FrameIdle: begin
               if (load_valid) begin
                  data_reg   <= result;
                  err_reg    <= error_code;
                  byte_idx   <= '0;
                  busy       <= 1'b1;
                  load_ready <= 1'b0;
                  state      <= FrameSend;
               end
            end
            FrameSend: begin
               if (byte_done && (byte_idx == LastIdx)) begin
                  byte_idx   <= '0;
                  busy       <= 1'b0;
                  load_ready <= 1'b1;
                  frame_done <= 1'b1;
                  state      <= FrameIdle;
               end else if (byte_valid && byte_ready) begin
                  byte_idx <= next_idx;
               end
            end
            default: begin
               busy       <= 1'b0;
               load_ready <= 1'b1;
               state      <= FrameIdle;
            end
         endcase
      end
   end

   uart_byte_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart (
      .clk       (clk),
      .rst       (rst),
      .byte_valid(byte_valid),
      .byte_data (byte_data),
      .byte_ready(byte_ready),
      .byte_done (byte_done),
      .tx        (tx)
   );

endmodule

// File: tb/tb_calc_result_tx.sv
// Scoreboard bench for calc_result_tx: stimulus queues expected frame bytes, a line
// receiver decodes tx and checks bytes, bit timing and frame_done latency.
module tb_calc_result_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [31:0] result = '0;
   logic [1:0]  error_code = '0;
   logic        tx;
   logic        busy;
   logic        frame_done;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rx_cnt   = 0;
   int frame_start = 0;
   int done_cnt = 0;

   logic [7:0] exp_q[$];
   logic [9:0] rx_bits;
   logic [7:0] exp_byte;
   bit         rx_ok;
   bit         rx_abort;

   calc_result_tx #(
      .CLKS_PER_BIT(10),
      .DATA_W      (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .load_valid(load_valid),
      .load_ready(load_ready),
      .result    (result),
      .error_code(error_code),
      .tx        (tx),
      .busy      (busy),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push7(input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
      exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
      exp_q.push_back(b3); exp_q.push_back(b4); exp_q.push_back(b5);
      exp_q.push_back(b6);
   endtask

   task automatic send(input logic [31:0] r, input logic [1:0] e);
      bit got;
      got = 0;
      @(posedge clk); #1;
      result = r; error_code = e; load_valid = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (load_ready) begin got = 1; break; end
      end
      check("accept_timeout", 32'(got), 1);
      @(posedge clk); #1;
      load_valid = 1'b0;
      @(negedge clk);
      check("start_bit_after_accept", 32'(tx), 0);
      check("busy_after_accept", 32'(busy), 1);
      check("ready_low_while_busy", 32'(load_ready), 0);
   endtask

   task automatic wait_done(input int max);
      bit got;
      got = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (frame_done) begin got = 1; break; end
      end
      check("frame_done_timeout", 32'(got), 1);
   endtask

   // Line receiver: every bit must hold one level for all 10 of its cycles.
   initial begin : rx_mon
      forever begin
         @(negedge clk);
         if (!rst && tx === 1'b0) begin
            rx_ok = 1; rx_abort = 0;
            if (rx_cnt == 0) frame_start = cyc;
            for (int b = 0; b < 10 && !rx_abort; b++) begin
               for (int s = 0; s < 10 && !rx_abort; s++) begin
                  if (b != 0 || s != 0) @(negedge clk);
                  if (rst) rx_abort = 1;
                  else if (s == 0) rx_bits[b] = tx;
                  else if (tx !== rx_bits[b]) rx_ok = 0;
               end
            end
            if (rx_abort) begin
               rx_cnt = 0;
            end else begin
               rx_cnt = (rx_cnt + 1) % 7;
               check("bit_timing", 32'(rx_ok), 1);
               check("stop_bit", 32'(rx_bits[9]), 1);
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_byte: got %0h, expected none", rx_bits[8:1]);
               end else begin
                  exp_byte = exp_q.pop_front();
                  check("frame_byte", 32'(rx_bits[8:1]), 32'(exp_byte));
               end
            end
         end
      end
   end

   initial begin : done_mon
      forever begin
         @(negedge clk);
         if (frame_done === 1'b1) begin
            done_cnt++;
            check("done_latency", 32'(cyc - frame_start), 700);
            check("done_after_last_byte", 32'(rx_cnt), 0);
            check("ready_on_done", 32'(load_ready), 1);
            check("busy_low_on_done", 32'(busy), 0);
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "simulation time limit");
   end

   initial begin : stim
      int d0;
      bit got;

      // Reset and idle
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("idle_tx", 32'(tx), 1);
         check("idle_ready", 32'(load_ready), 1);
         check("idle_busy", 32'(busy), 0);
         check("idle_done", 32'(frame_done), 0);
      end

      // Single frame: 452
      push7(8'hA5, 8'h00, 8'h00, 8'h01, 8'hC4, 8'h00, 8'hC5);
      send(32'h0000_01C4, 2'b00);
      wait_done(800);

      // Divide-by-zero status
      push7(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02);
      send(32'h0000_0000, 2'b10);
      wait_done(800);

      // Back-to-back with load_valid held high
      push7(8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h22);
      @(posedge clk); #1;
      result = 32'hDEAD_BEEF; error_code = 2'b00; load_valid = 1'b1;
      @(negedge clk);
      check("b2b_first_ready", 32'(load_ready), 1);
      @(posedge clk); #1;
      result = 32'h0000_0001;
      @(negedge clk);
      check("b2b_first_busy", 32'(busy), 1);
      wait_done(800);
      check("b2b_ready_on_done", 32'(load_ready), 1);
      push7(8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01);
      @(posedge clk); #1;
      load_valid = 1'b0;
      @(negedge clk);
      check("b2b_second_start", 32'(tx), 0);
      check("b2b_second_busy", 32'(busy), 1);
      wait_done(800);

      // Request while busy is dropped
      push7(8'hA5, 8'h0F, 8'h0F, 8'hA0, 8'hA0, 8'h01, 8'h01);
      send(32'h0F0F_A0A0, 2'b01);
      d0 = done_cnt;
      repeat (150) @(posedge clk);
      #1;
      result = 32'h1234_5678; error_code = 2'b11; load_valid = 1'b1;
      @(negedge clk);
      check("busy_ignore_ready", 32'(load_ready), 0);
      @(posedge clk); #1;
      load_valid = 1'b0;
      wait_done(800);
      repeat (100) @(negedge clk);
      check("busy_ignore_one_done", 32'(done_cnt - d0), 1);
      check("busy_ignore_idle_tx", 32'(tx), 1);
      check("busy_ignore_not_queued", 32'(busy), 0);

      // Reset during byte 3
      push7(8'hA5, 8'hCA, 8'hFE, 8'h00, 8'h13, 8'h01, 8'h26);
      send(32'hCAFE_0013, 2'b01);
      got = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (rx_cnt == 3) begin got = 1; break; end
      end
      check("reach_byte3_timeout", 32'(got), 1);
      repeat (35) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_tx", 32'(tx), 1);
      check("abort_busy", 32'(busy), 0);
      check("abort_ready", 32'(load_ready), 1);
      check("abort_no_done", 32'(frame_done), 0);
      exp_q.delete();
      d0 = done_cnt;
      repeat (120) @(negedge clk);
      check("abort_no_done_later", 32'(done_cnt - d0), 0);
      check("abort_line_idle", 32'(tx), 1);

      push7(8'hA5, 8'h80, 8'h01, 8'h7F, 8'h3C, 8'h01, 8'hC3);
      send(32'h8001_7F3C, 2'b01);
      wait_done(800);
      repeat (20) @(negedge clk);

      check("expected_queue_empty", 32'(exp_q.size()), 0);
      check("total_frames", 32'(done_cnt), 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
